cgra_bank_stream_reader: RTL and testbench

- Initiator-side companion to the CGRA SRAM bank wrapper.
- Accepts a strided-read command and issues read requests on the bank's req/we/addr/wdata/be port.
- Captures read data, which returns with 1-cycle latency, into a small FIFO.
- Presents the data as a valid/ready stream with a last flag. It also owns the bank's retention control, asserting retention only when fully idle.

---
 rtl/cgra_stream_pkg.sv | 22 ++
 rtl/cgra_stream_fifo.sv | 71 +++++++
 rtl/cgra_bank_stream_reader.sv | 186 ++++++++++++++++++
 tb/tb_cgra_bank_stream_reader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_stream_pkg.sv
// cgra_stream_pkg
//   Shared types and constants for the CGRA bank stream reader and its FIFO.
//   - state_e      : command FSM states
//   - fifo_entry_t : one captured read word plus its end-of-command flag
//   - MEM_BE_ALL   : byte enable driven on every bank access (full word)
package cgra_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } fifo_entry_t;

  localparam logic [3:0] MEM_BE_ALL = 4'hF;

endpackage

// File: rtl/cgra_stream_fifo.sv
// cgra_stream_fifo
//   Synchronous FIFO of fifo_entry_t with first-word-fall-through output.
//   Push and pop in the same cycle are both honoured and leave the count unchanged.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset (flushes to empty)
//     push_i/entry_i  write one entry (ignored when full)
//     pop_i           consume the head entry (ignored when empty)
//     head_o          current head entry
//     count_o         number of stored entries, 0..DEPTH
//     full_o/empty_o  occupancy flags
module cgra_stream_fifo
  import cgra_stream_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CntW  = $clog2(DEPTH + 1),
  localparam int PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  fifo_entry_t       entry_i,
  input  logic              pop_i,
  output fifo_entry_t       head_o,
  output logic [CntW-1:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  fifo_entry_t         r_mem [DEPTH];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]     r_count;
  logic                w_push;
  logic                w_pop;

  assign full_o  = (r_count == CntW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // Storage carries no reset: only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= entry_i;
    end
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PtrW'(DEPTH - 1)) ? '0 : r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(DEPTH - 1)) ? '0 : r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cgra_bank_stream_reader.sv
// cgra_bank_stream_reader
//   Reads a strided sequence of words from a CGRA SRAM bank and presents them
//   as a valid/ready stream with a last flag. It also drives the bank's
//   retention control, so the bank only sleeps while this reader is idle.
//   Ports:
//     cmd_*            command handshake: start address, word count, stride
//     out_*            output stream (data, last) from the FIFO head
//     busy_o / done_o  command in progress / one-cycle completion pulse
//     retentive_req_i  system request to put the bank into retention
//     mem_*            bank port (read-only use; 1-cycle read latency)
//   Optional build macro CGRA_STREAM_PERF_CNT_EN adds perf_stall_cycles_o,
//   a saturating count of RUN/DRAIN cycles where the consumer stalls the stream.
module cgra_bank_stream_reader
  import cgra_stream_pkg::*;
#(
  parameter  int NUM_WORDS  = 1024,
  parameter  int FIFO_DEPTH = 4,
  parameter  int LEN_WIDTH  = 16,
  localparam int AddrWidth  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0] cmd_len_i,
  input  logic [AddrWidth-1:0] cmd_stride_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 done_o,
`ifdef CGRA_STREAM_PERF_CNT_EN
  output logic [31:0]          perf_stall_cycles_o,
`endif
  input  logic                 retentive_req_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_be_o,
  input  logic [31:0]          mem_rdata_i,
  output logic                 mem_set_retentive_no
);

  localparam int FifoCntW = $clog2(FIFO_DEPTH + 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [AddrWidth-1:0]  r_addr;
  logic [AddrWidth-1:0]  r_stride;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_ret_n;
  logic                  w_cmd_accept;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_pop;
  logic                  w_last_issue;
  fifo_entry_t           w_push_entry;
  fifo_entry_t           w_head;
  logic [FifoCntW-1:0]   w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  // A request is allowed only when every word already stored or still on
  // its way back from the bank fits in the FIFO, so capture never overflows.
  // The full check is redundant with the credit sum but keeps push safe.
  assign w_credit     = (32'(w_fifo_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH);
  assign w_issue      = (r_state == RUN) & w_credit & ~w_fifo_full;
  assign w_last_issue = w_issue & (r_remaining == LEN_WIDTH'(1));
  assign w_cmd_accept = cmd_valid_i & cmd_ready_o;
  assign w_pop        = out_valid_o & out_ready_i;

  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);
  assign mem_req_o    = w_issue;
  assign mem_we_o     = 1'b0;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = 32'h0;
  assign mem_be_o     = MEM_BE_ALL;
  assign mem_set_retentive_no = r_ret_n;

  assign out_valid_o  = ~w_fifo_empty;
  assign out_data_o   = w_head.data;
  assign out_last_o   = w_head.last & ~w_fifo_empty;

  assign w_push_entry.data = mem_rdata_i;
  assign w_push_entry.last = r_inflight_last;

  cgra_stream_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (r_inflight),
    .entry_i (w_push_entry),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .count_o (w_fifo_count),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state; commands are only taken once the bank has been awake for a
  // cycle, which is exactly when the registered retention output reads 1.
  always_comb begin
    w_state_next = r_state;
    cmd_ready_o  = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready_o = r_ret_n;
        if (cmd_valid_i && r_ret_n) begin
          w_state_next = (cmd_len_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (w_last_issue) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_inflight && w_fifo_empty) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Command datapath, in-flight tracking and retention register. A pending
  // command clears the retention request so a sleeping bank wakes for it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr          <= '0;
      r_stride        <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_ret_n         <= 1'b1;
    end else begin
      if (w_cmd_accept) begin
        r_addr      <= cmd_addr_i;
        r_stride    <= cmd_stride_i;
        r_remaining <= cmd_len_i;
      end else if (w_issue) begin
        r_addr      <= r_addr + r_stride;
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;
      r_ret_n         <= ~(retentive_req_i & (r_state == IDLE) & ~cmd_valid_i);
    end
  end

`ifdef CGRA_STREAM_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  // Consumer back-pressure while a command is active, saturating.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (w_cmd_accept) begin
      r_stall_cnt <= '0;
    end else if (((r_state == RUN) || (r_state == DRAIN)) && out_valid_o &&
                 !out_ready_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cycles_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cgra_bank_stream_reader.sv
// tb_cgra_bank_stream_reader
//   Directed bench: a table of strided commands plus hand-written sequences
//   for back-pressure, zero length, retention wake-up and mid-command reset.
module tb_cgra_bank_stream_reader;

  localparam int NW = 1024;
  localparam int AW = 10;
  localparam int LW = 16;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] cmd_stride;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          ret_req;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;
  logic          mem_ret_n;
`ifdef CGRA_STREAM_PERF_CNT_EN
  logic [31:0]   perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int doneCnt = 0;
  int validCnt = 0;
  int retBusyViol = 0;
  logic [AW-1:0] reqQ[$];
  int            reqCycQ[$];
  logic [32:0]   outQ[$];

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    logic [AW-1:0] stride;
    logic [AW-1:0] expLastAddr;
  } vec_t;

  vec_t vecs[4];

  cgra_bank_stream_reader #(
    .NUM_WORDS  (NW),
    .FIFO_DEPTH (4),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .cmd_valid_i          (cmd_valid),
    .cmd_ready_o          (cmd_ready),
    .cmd_addr_i           (cmd_addr),
    .cmd_len_i            (cmd_len),
    .cmd_stride_i         (cmd_stride),
    .out_valid_o          (out_valid),
    .out_ready_i          (out_ready),
    .out_data_o           (out_data),
    .out_last_o           (out_last),
    .busy_o               (busy),
    .done_o               (done),
`ifdef CGRA_STREAM_PERF_CNT_EN
    .perf_stall_cycles_o  (perf_stall),
`endif
    .retentive_req_i      (ret_req),
    .mem_req_o            (mem_req),
    .mem_we_o             (mem_we),
    .mem_addr_o           (mem_addr),
    .mem_wdata_o          (mem_wdata),
    .mem_be_o             (mem_be),
    .mem_rdata_i          (mem_rdata),
    .mem_set_retentive_no (mem_ret_n)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank content is a fixed function of the address.
  function automatic logic [31:0] memWord(input logic [AW-1:0] a);
    return 32'h5A00_0000 ^ {a, 6'h0, a, 6'h0};
  endfunction

  // Bank model: read data appears the cycle after a request.
  always @(posedge clk) begin
    mem_rdata <= mem_req ? memWord(mem_addr) : 32'h0;
  end

  // Monitor on the inactive edge: logs requests, delivered words, done
  // pulses, valid cycles and any retention assertion while busy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        reqQ.push_back(mem_addr);
        reqCycQ.push_back(cycle);
      end
      if (out_valid && out_ready) outQ.push_back({out_last, out_data});
      if (out_valid) validCnt++;
      if (done) doneCnt++;
      if (busy && !mem_ret_n) retBusyViol++;
    end
    cycle++;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearLogs();
    reqQ.delete();
    reqCycQ.delete();
    outQ.delete();
    validCnt = 0;
  endtask

  // Present one command and hold it until the DUT accepts it; reports how
  // many cycles the command waited with cmd_ready low.
  task automatic applyStimulus(input logic [AW-1:0] a, input int len,
                               input logic [AW-1:0] s, output int waits);
    logic seen;
    seen = 1'b0;
    waits = 0;
    @(posedge clk);
    #1;
    cmd_addr   = a;
    cmd_len    = LW'(len);
    cmd_stride = s;
    cmd_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        seen = 1'b1;
        break;
      end
      waits++;
    end
    checkOutput("cmd accepted", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a done pulse, then confirm it was a single pulse.
  task automatic waitDone(input int budget);
    int start;
    start = doneCnt;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (doneCnt != start) break;
    end
    checkOutput("done within budget", 32'(doneCnt != start), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("done single pulse", 32'(doneCnt - start), 32'd1);
    checkOutput("idle after done", {30'b0, busy, out_valid}, 32'd0);
  endtask

  // Compare logged requests and delivered words against the strided model.
  task automatic checkRun(input string tag, input logic [AW-1:0] a, input int len,
                          input logic [AW-1:0] s, input bit backToBack);
    logic [AW-1:0] ea;
    logic [31:0]   act;
    logic [32:0]   w;
    checkOutput({tag, " req count"}, 32'(reqQ.size()), 32'(len));
    checkOutput({tag, " word count"}, 32'(outQ.size()), 32'(len));
    for (int i = 0; i < len; i++) begin
      ea  = AW'((int'(a) + i * int'(s)) % NW);
      act = (i < reqQ.size()) ? {22'b0, reqQ[i]} : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s addr[%0d]", tag, i), act, {22'b0, ea});
      if (backToBack && i < reqCycQ.size())
        checkOutput($sformatf("%s req cycle[%0d]", tag, i), 32'(reqCycQ[i] - reqCycQ[0]), 32'(i));
      w = (i < outQ.size()) ? outQ[i] : 33'h0;
      checkOutput($sformatf("%s data[%0d]", tag, i), w[31:0], memWord(ea));
      checkOutput($sformatf("%s last[%0d]", tag, i), 32'(w[32]), 32'(i == len - 1));
    end
  endtask

  initial begin
    int waits;
    int k;

    vecs[0] = '{addr: 10'd10,   len: 4, stride: 10'd1,   expLastAddr: 10'd13};
    vecs[1] = '{addr: 10'd1020, len: 6, stride: 10'd3,   expLastAddr: 10'd11};
    vecs[2] = '{addr: 10'd5,    len: 3, stride: 10'd0,   expLastAddr: 10'd5};
    vecs[3] = '{addr: 10'd1000, len: 5, stride: 10'd512, expLastAddr: 10'd1000};

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_stride = '0;
    out_ready  = 1'b1;
    ret_req    = 1'b0;

    // Reset values while reset is held.
    #12;
    checkOutput("rst cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_last", 32'(out_last), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst mem_addr", {22'b0, mem_addr}, 32'd0);
    checkOutput("rst retention_n", 32'(mem_ret_n), 32'd1);
    checkOutput("mem_we", 32'(mem_we), 32'd0);
    checkOutput("mem_wdata", mem_wdata, 32'd0);
    checkOutput("mem_be", {28'b0, mem_be}, 32'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] table-driven strided reads");
    for (int v = 0; v < 4; v++) begin
      clearLogs();
      applyStimulus(vecs[v].addr, vecs[v].len, vecs[v].stride, waits);
      waitDone(40);
      checkRun($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].stride, 1'b1);
      checkOutput($sformatf("vec%0d last addr", v),
                  (reqQ.size() != 0) ? {22'b0, reqQ[reqQ.size() - 1]} : 32'hFFFF_FFFF,
                  {22'b0, vecs[v].expLastAddr});
    end

    $display("[TB] zero-length command");
    clearLogs();
    applyStimulus(10'd77, 0, 10'd1, waits);
    waitDone(4);
    checkOutput("len0 no requests", 32'(reqQ.size()), 32'd0);
    checkOutput("len0 no valid", 32'(validCnt), 32'd0);

    $display("[TB] back-pressure: 8 words with consumer stalled");
    clearLogs();
    out_ready = 1'b0;
    applyStimulus(10'd300, 8, 10'd1, waits);
    repeat (10) @(negedge clk);
    checkOutput("stall req count", 32'(reqQ.size()), 32'd4);
    checkOutput("stall mem_req low", 32'(mem_req), 32'd0);
    checkOutput("stall out_valid", 32'(out_valid), 32'd1);
    checkOutput("stall head held", out_data, memWord(10'd300));
    checkOutput("stall no pops", 32'(outQ.size()), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDone(40);
    checkRun("stall", 10'd300, 8, 10'd1, 1'b0);

    $display("[TB] retention wake-up");
    clearLogs();
    @(posedge clk);
    #1;
    ret_req = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("ret asserted idle", 32'(mem_ret_n), 32'd0);
    checkOutput("ret cmd_ready low", 32'(cmd_ready), 32'd0);
    applyStimulus(10'd50, 3, 10'd2, waits);
    checkOutput("ret wake cycles", 32'(waits), 32'd1);
    waitDone(40);
    checkRun("ret", 10'd50, 3, 10'd2, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("ret re-asserted idle", 32'(mem_ret_n), 32'd0);
    checkOutput("ret never while busy", 32'(retBusyViol), 32'd0);
    @(posedge clk);
    #1;
    ret_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset in the middle of a command");
    clearLogs();
    applyStimulus(10'd100, 10, 10'd1, waits);
    for (k = 0; k < 30; k++) begin
      if (outQ.size() >= 3) break;
      @(negedge clk);
    end
    checkOutput("mid-run 3 words", 32'(outQ.size() >= 3), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst out_last", 32'(out_last), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst done", 32'(done), 32'd0);
    checkOutput("midrst mem_req", 32'(mem_req), 32'd0);
    checkOutput("midrst mem_addr", {22'b0, mem_addr}, 32'd0);
    checkOutput("midrst cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("midrst retention_n", 32'(mem_ret_n), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearLogs();
    applyStimulus(10'd200, 3, 10'd1, waits);
    waitDone(40);
    checkRun("post-rst", 10'd200, 3, 10'd1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
